data_memory_responder: RTL and testbench

//  Responder end of the core's data-memory interface (memread/memwrite/data_address/writedata -> received_data).

---
 rtl/data_memory_responder.sv | 159 +++++++++++++++
 tb/tb_data_memory_responder.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: responder for the core's data-memory port.
// Decodes each access into a word RAM or a small peripheral window that
// holds GPIO out/in and a free-running timer with a sticky compare IRQ.
// Load data is combinational so it can feed the MEM/WB register directly.
module data_memory_responder #(
  parameter int unsigned memory_depth = 64,
  parameter logic [31:0] ram_base     = 32'h1001_0000,
  parameter logic [31:0] io_base      = 32'h1001_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] data_address,
  input  logic [31:0] writedata,
  output logic [31:0] received_data,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        timer_irq,
  output logic        bus_error
);

  localparam int unsigned idx_w     = (memory_depth > 1) ? $clog2(memory_depth) : 1;
  localparam logic [31:0] ram_bytes = 32'(memory_depth * 4);

  typedef enum logic [2:0] {
    IO_NONE,
    IO_GPIO_OUT,
    IO_GPIO_IN,
    IO_TMR_COUNT,
    IO_TMR_CMP,
    IO_TMR_CTRL
  } io_reg_e;

  // Storage and peripheral state
  logic [31:0] r_mem [memory_depth];
  logic [7:0]  r_gpio_out;
  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_enable;
  logic        r_irq;

  // Address decode
  logic [31:0]      w_ram_off;
  logic [31:0]      w_io_off;
  logic [idx_w-1:0] w_ram_idx;
  logic             w_ram_hit;
  logic             w_misaligned;
  logic             w_fault;
  logic             w_wr_ok;
  logic             w_ram_we;
  logic             w_wr_gpio;
  logic             w_wr_cmp;
  logic             w_wr_ctrl;
  io_reg_e          w_io_sel;

  // Offsets wrap for addresses below a base, so a single unsigned compare
  // bounds the RAM window on both sides.
  assign w_ram_off    = data_address - ram_base;
  assign w_io_off     = data_address - io_base;
  assign w_ram_idx    = w_ram_off[idx_w+1:2];
  assign w_ram_hit    = (w_ram_off < ram_bytes);
  assign w_misaligned = (data_address[1:0] != 2'b00);

  // Select which peripheral register the address names
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_io_sel = IO_NONE;
    case (w_io_off)
      32'h00:  w_io_sel = IO_GPIO_OUT;
      32'h04:  w_io_sel = IO_GPIO_IN;
      32'h08:  w_io_sel = IO_TMR_COUNT;
      32'h0C:  w_io_sel = IO_TMR_CMP;
      32'h10:  w_io_sel = IO_TMR_CTRL;
      default: w_io_sel = IO_NONE;
    endcase
  end

  assign w_fault   = w_misaligned || (!w_ram_hit && (w_io_sel == IO_NONE));
  assign bus_error = (memread || memwrite) && w_fault;

  // A write presented while reset is high is dropped everywhere, RAM included.
  assign w_wr_ok   = memwrite && !w_fault && !reset;
  assign w_ram_we  = w_wr_ok && w_ram_hit;
  assign w_wr_gpio = w_wr_ok && !w_ram_hit && (w_io_sel == IO_GPIO_OUT);
  assign w_wr_cmp  = w_wr_ok && !w_ram_hit && (w_io_sel == IO_TMR_CMP);
  assign w_wr_ctrl = w_wr_ok && !w_ram_hit && (w_io_sel == IO_TMR_CTRL);

  // Word RAM write port
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto plain memory; software
    // must write a word before relying on its contents.
    if (w_ram_we) begin
      r_mem[w_ram_idx] <= writedata;
    end
  end

  // GPIO, input synchroniser, timer and sticky IRQ
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop read the pre-edge value
    // of the others, which is what keeps the match/clear race well defined.
    if (reset) begin
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_count    <= '0;
      r_cmp      <= 32'hFFFF_FFFF;
      r_enable   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      if (r_enable) begin
        r_count <= r_count + 32'd1;
      end
      if (w_wr_gpio) begin
        r_gpio_out <= writedata[7:0];
      end
      if (w_wr_cmp) begin
        r_cmp <= writedata;
      end
      if (w_wr_ctrl) begin
        r_enable <= writedata[0];
      end
      // A match in the same cycle as a W1C keeps the flag set.
      if (r_enable && (r_count == r_cmp)) begin
        r_irq <= 1'b1;
      end else if (w_wr_ctrl && writedata[1]) begin
        r_irq <= 1'b0;
      end
    end
  end

  // Zero-latency load data; faulting or idle cycles return zero
  always_comb begin
    received_data = '0;
    if (memread && !w_fault) begin
      if (w_ram_hit) begin
        received_data = r_mem[w_ram_idx];
      end else begin
        case (w_io_sel)
          IO_GPIO_OUT:  received_data = {24'h0, r_gpio_out};
          IO_GPIO_IN:   received_data = {24'h0, r_sync2};
          IO_TMR_COUNT: received_data = r_count;
          IO_TMR_CMP:   received_data = r_cmp;
          IO_TMR_CTRL:  received_data = {30'h0, r_irq, r_enable};
          default:      received_data = '0;
        endcase
      end
    end
  end

  assign gpio_out  = r_gpio_out;
  assign timer_irq = r_irq;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios plus a randomized mix,
// all compared against a behavioural memory-map model held in the bench.
module tb_data_memory_responder;

  localparam logic [31:0] RAM = 32'h1001_0000;
  localparam logic [31:0] IO  = 32'h1001_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] data_address;
  logic [31:0] writedata;
  logic [31:0] received_data;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        timer_irq;
  logic        bus_error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_memory_responder dut (
    .clk          (clk),
    .reset        (reset),
    .memread      (memread),
    .memwrite     (memwrite),
    .data_address (data_address),
    .writedata    (writedata),
    .received_data(received_data),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .timer_irq    (timer_irq),
    .bus_error    (bus_error)
  );

  // Behavioural model of the memory map
  logic [31:0] m_mem [64];
  logic [7:0]  m_gpio_out;
  logic [7:0]  m_seen [2];   // gpio_in as seen at the last edge and the one before
  logic [31:0] m_count;
  logic [31:0] m_cmp;
  logic        m_en;
  logic        m_irq;

  function automatic void model_read(input logic rd, input logic wr, input logic [31:0] a,
                                     output logic [31:0] d, output logic err);
    logic [31:0] ram_off;
    logic [31:0] io_off;
    logic [31:0] v;
    logic        mapped;
    ram_off = a - RAM;
    io_off  = a - IO;
    v       = 32'h0;
    mapped  = 1'b1;
    if (ram_off < 32'd256) begin
      v = m_mem[ram_off[7:2]];
    end else begin
      case (io_off)
        32'h00:  v = {24'h0, m_gpio_out};
        32'h04:  v = {24'h0, m_seen[1]};
        32'h08:  v = m_count;
        32'h0C:  v = m_cmp;
        32'h10:  v = {30'h0, m_irq, m_en};
        default: mapped = 1'b0;
      endcase
    end
    err = (rd || wr) && ((a[1:0] != 2'b00) || !mapped);
    d   = (rd && !err) ? v : 32'h0;
  endfunction

  function automatic void model_edge(input logic rd, input logic wr, input logic [31:0] a,
                                     input logic [31:0] d, input logic rst, input logic [7:0] gin);
    logic [31:0] dummy;
    logic [31:0] ram_off;
    logic        err;
    logic        match;
    if (rst) begin
      m_gpio_out = 8'h0;
      m_seen[0]  = 8'h0;
      m_seen[1]  = 8'h0;
      m_count    = 32'h0;
      m_cmp      = 32'hFFFF_FFFF;
      m_en       = 1'b0;
      m_irq      = 1'b0;
      return;
    end
    model_read(rd, wr, a, dummy, err);
    match     = m_en && (m_count == m_cmp);
    m_seen[1] = m_seen[0];
    m_seen[0] = gin;
    if (m_en) m_count = m_count + 32'd1;
    if (wr && !err) begin
      ram_off = a - RAM;
      if (ram_off < 32'd256) begin
        m_mem[ram_off[7:2]] = d;
      end else if (a - IO == 32'h00) begin
        m_gpio_out = d[7:0];
      end else if (a - IO == 32'h0C) begin
        m_cmp = d;
      end else if (a - IO == 32'h10) begin
        m_en = d[0];
        if (d[1]) m_irq = 1'b0;
      end
    end
    if (match) m_irq = 1'b1;
  endfunction

  // One bus cycle: drive, sample combinational outputs at negedge, advance model at posedge
  task automatic bus_cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] got_d, output logic [31:0] exp_d,
                           output logic got_e, output logic exp_e);
    memread      = rd;
    memwrite     = wr;
    data_address = a;
    writedata    = d;
    model_read(rd, wr, a, exp_d, exp_e);
    @(negedge clk);
    got_d = received_data;
    got_e = bus_error;
    @(posedge clk);
    model_edge(rd, wr, a, d, reset, gpio_in);
    #1;
    memread  = 1'b0;
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] gd, ed;
    logic ge, ee;
    logic [31:0] regs [4];
    logic [31:0] want [4];
    reset = 1'b1;
    for (int i = 0; i < 3; i++) bus_cycle(1'b0, 1'b0, 32'h0, 32'h0, gd, ed, ge, ee);
    reset = 1'b0;
    n_checks++;
    if (gpio_out !== 8'h00) begin n_errors++; $display("FAIL reset_gpio_out got=%h exp=00", gpio_out); end
    n_checks++;
    if (timer_irq !== 1'b0) begin n_errors++; $display("FAIL reset_timer_irq got=%b exp=0", timer_irq); end
    regs[0] = IO + 32'h08; want[0] = 32'h0;
    regs[1] = IO + 32'h0C; want[1] = 32'hFFFF_FFFF;
    regs[2] = IO + 32'h10; want[2] = 32'h0;
    regs[3] = IO + 32'h00; want[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      bus_cycle(1'b1, 1'b0, regs[i], 32'h0, gd, ed, ge, ee);
      n_checks++;
      if (gd !== want[i] || ge !== 1'b0) begin
        n_errors++; $display("FAIL reset_reg addr=%h got=%h/%b exp=%h/0", regs[i], gd, ge, want[i]);
      end
    end
    bus_cycle(1'b0, 1'b0, RAM, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (gd !== 32'h0 || ge !== 1'b0) begin n_errors++; $display("FAIL idle_read got=%h/%b exp=0/0", gd, ge); end
  endtask

  task automatic test_ram();
    logic [31:0] gd, ed, a;
    logic ge, ee;
    for (int i = 0; i < 64; i++) bus_cycle(1'b0, 1'b1, RAM + 32'(i * 4), $urandom, gd, ed, ge, ee);
    bus_cycle(1'b0, 1'b1, 32'h1001_000C, 32'hDEAD_BEEF, gd, ed, ge, ee);
    bus_cycle(1'b1, 1'b0, 32'h1001_000C, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (gd !== 32'hDEAD_BEEF || ge !== 1'b0) begin
      n_errors++; $display("FAIL ram_deadbeef got=%h/%b exp=deadbeef/0", gd, ge);
    end
    for (int i = 0; i < 40; i++) begin
      a = RAM + 32'($urandom_range(0, 63) * 4);
      bus_cycle(1'b1, 1'b0, a, 32'h0, gd, ed, ge, ee);
      n_checks++;
      if (gd !== ed || ge !== ee) begin
        n_errors++; $display("FAIL ram_read addr=%h got=%h/%b exp=%h/%b", a, gd, ge, ed, ee);
      end
    end
  endtask

  task automatic test_rw_same();
    logic [31:0] gd, ed;
    logic ge, ee;
    bus_cycle(1'b0, 1'b1, RAM, 32'h11, gd, ed, ge, ee);
    bus_cycle(1'b1, 1'b1, RAM, 32'h22, gd, ed, ge, ee);
    n_checks++;
    if (gd !== 32'h11) begin n_errors++; $display("FAIL rw_same_old got=%h exp=00000011", gd); end
    bus_cycle(1'b1, 1'b0, RAM, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (gd !== 32'h22) begin n_errors++; $display("FAIL rw_same_new got=%h exp=00000022", gd); end
  endtask

  task automatic test_errors();
    logic [31:0] gd, ed;
    logic ge, ee;
    logic [31:0] bad [9];
    bad[0] = RAM + 32'h2;    bad[1] = RAM + 32'h1;  bad[2] = RAM + 32'h3;
    bad[3] = 32'h1000_FFFC;  bad[4] = RAM + 32'h100; bad[5] = IO + 32'h14;
    bad[6] = IO + 32'h100;   bad[7] = 32'h0;        bad[8] = IO + 32'h11;
    bus_cycle(1'b0, 1'b1, RAM + 32'h4, 32'h55, gd, ed, ge, ee);
    bus_cycle(1'b0, 1'b1, RAM + 32'h6, 32'h66, gd, ed, ge, ee);
    n_checks++;
    if (ge !== 1'b1) begin n_errors++; $display("FAIL misaligned_write_err got=%b exp=1", ge); end
    bus_cycle(1'b1, 1'b0, RAM + 32'h4, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (gd !== 32'h55 || ge !== 1'b0) begin n_errors++; $display("FAIL misaligned_no_effect got=%h/%b exp=00000055/0", gd, ge); end
    for (int i = 0; i < 9; i++) begin
      bus_cycle(1'b1, 1'b0, bad[i], 32'h0, gd, ed, ge, ee);
      n_checks++;
      if (gd !== 32'h0 || ge !== 1'b1) begin n_errors++; $display("FAIL bad_read addr=%h got=%h/%b exp=0/1", bad[i], gd, ge); end
      bus_cycle(1'b0, 1'b1, bad[i], $urandom, gd, ed, ge, ee);
      n_checks++;
      if (ge !== 1'b1) begin n_errors++; $display("FAIL bad_write addr=%h got=%b exp=1", bad[i], ge); end
    end
    bus_cycle(1'b0, 1'b0, RAM + 32'h2, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (ge !== 1'b0) begin n_errors++; $display("FAIL no_access_err got=%b exp=0", ge); end
    bus_cycle(1'b0, 1'b1, RAM + 32'hFC, 32'h0BAD_F00D, gd, ed, ge, ee);
    bus_cycle(1'b1, 1'b0, RAM + 32'hFC, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (gd !== 32'h0BAD_F00D || ge !== 1'b0) begin n_errors++; $display("FAIL last_word got=%h/%b exp=0badf00d/0", gd, ge); end
    bus_cycle(1'b0, 1'b1, IO + 32'h4, 32'hFF, gd, ed, ge, ee);
    n_checks++;
    if (ge !== 1'b0) begin n_errors++; $display("FAIL gpio_in_write_err got=%b exp=0", ge); end
    for (int i = 0; i < 64; i++) begin
      bus_cycle(1'b1, 1'b0, RAM + 32'(i * 4), 32'h0, gd, ed, ge, ee);
      n_checks++;
      if (gd !== ed) begin n_errors++; $display("FAIL ram_after_bad idx=%0d got=%h exp=%h", i, gd, ed); end
    end
  endtask

  task automatic test_timer();
    logic [31:0] gd, ed, held;
    logic ge, ee;
    bus_cycle(1'b0, 1'b1, IO + 32'h0C, 32'd5, gd, ed, ge, ee);
    bus_cycle(1'b0, 1'b1, IO + 32'h10, 32'd1, gd, ed, ge, ee);
    for (int k = 0; k < 8; k++) begin
      bus_cycle(1'b1, 1'b0, IO + 32'h08, 32'h0, gd, ed, ge, ee);
      n_checks++;
      if (gd !== 32'(k) || gd !== ed) begin n_errors++; $display("FAIL timer_count k=%0d got=%h exp=%h", k, gd, k); end
      n_checks++;
      if (timer_irq !== (k >= 5)) begin n_errors++; $display("FAIL timer_irq k=%0d got=%b exp=%b", k, timer_irq, k >= 5); end
    end
    bus_cycle(1'b0, 1'b1, IO + 32'h10, 32'd3, gd, ed, ge, ee);
    n_checks++;
    if (timer_irq !== 1'b0) begin n_errors++; $display("FAIL irq_w1c got=%b exp=0", timer_irq); end
    bus_cycle(1'b1, 1'b0, IO + 32'h10, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (gd !== 32'h1) begin n_errors++; $display("FAIL ctrl_after_clear got=%h exp=00000001", gd); end
    // Clear lands in the very cycle the next match occurs
    bus_cycle(1'b0, 1'b1, IO + 32'h0C, m_count + 32'd3, gd, ed, ge, ee);
    for (int i = 0; i < 10 && m_count != m_cmp; i++) bus_cycle(1'b0, 1'b0, 32'h0, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (m_count != m_cmp) begin n_errors++; $display("FAIL match_window got=%h exp=%h", m_count, m_cmp); end
    bus_cycle(1'b0, 1'b1, IO + 32'h10, 32'd3, gd, ed, ge, ee);
    n_checks++;
    if (timer_irq !== 1'b1) begin n_errors++; $display("FAIL set_beats_clear got=%b exp=1", timer_irq); end
    // Disabled counter holds; writes to COUNT are ignored
    bus_cycle(1'b0, 1'b1, IO + 32'h10, 32'd0, gd, ed, ge, ee);
    bus_cycle(1'b1, 1'b0, IO + 32'h08, 32'h0, held, ed, ge, ee);
    bus_cycle(1'b0, 1'b1, IO + 32'h08, 32'h0, gd, ed, ge, ee);
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0, gd, ed, ge, ee);
    bus_cycle(1'b1, 1'b0, IO + 32'h08, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (gd !== held || gd !== ed) begin n_errors++; $display("FAIL count_hold got=%h exp=%h", gd, ed); end
    n_checks++;
    if (timer_irq !== 1'b1) begin n_errors++; $display("FAIL irq_sticky got=%b exp=1", timer_irq); end
  endtask

  task automatic test_gpio();
    logic [31:0] gd, ed;
    logic ge, ee;
    logic [31:0] want [3];
    want[0] = 32'h0; want[1] = 32'h0; want[2] = 32'hA5;
    gpio_in = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      bus_cycle(1'b1, 1'b0, IO + 32'h04, 32'h0, gd, ed, ge, ee);
      n_checks++;
      if (gd !== want[i]) begin n_errors++; $display("FAIL gpio_in_sync step=%0d got=%h exp=%h", i, gd, want[i]); end
    end
    bus_cycle(1'b0, 1'b1, IO, 32'h1FF, gd, ed, ge, ee);
    n_checks++;
    if (gpio_out !== 8'hFF) begin n_errors++; $display("FAIL gpio_out_pin got=%h exp=ff", gpio_out); end
    bus_cycle(1'b1, 1'b0, IO, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (gd !== 32'h0000_00FF) begin n_errors++; $display("FAIL gpio_out_read got=%h exp=000000ff", gd); end
    for (int i = 0; i < 12; i++) begin
      gpio_in = 8'($urandom);
      bus_cycle(1'b1, 1'b0, IO + 32'h04, 32'h0, gd, ed, ge, ee);
      n_checks++;
      if (gd !== ed) begin n_errors++; $display("FAIL gpio_in_rand i=%0d got=%h exp=%h", i, gd, ed); end
    end
  endtask

  task automatic test_random();
    logic [31:0] gd, ed, a, d;
    logic ge, ee, rd, wr;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = RAM + 32'($urandom_range(0, 63) * 4);
        6, 7:             a = IO + 32'($urandom_range(0, 4) * 4);
        8:                a = RAM + 32'($urandom_range(0, 32'h4FF));
        default:          a = $urandom;
      endcase
      rd = 1'($urandom);
      wr = ($urandom_range(0, 3) == 0);
      d  = $urandom;
      gpio_in = 8'($urandom);
      bus_cycle(rd, wr, a, d, gd, ed, ge, ee);
      n_checks++;
      if (gd !== ed || ge !== ee) begin
        n_errors++; $display("FAIL rand_access i=%0d addr=%h got=%h/%b exp=%h/%b", i, a, gd, ge, ed, ee);
      end
      n_checks++;
      if (gpio_out !== m_gpio_out || timer_irq !== m_irq) begin
        n_errors++; $display("FAIL rand_outputs i=%0d got=%h/%b exp=%h/%b", i, gpio_out, timer_irq, m_gpio_out, m_irq);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] gd, ed;
    logic ge, ee;
    bus_cycle(1'b0, 1'b1, IO + 32'h10, 32'd0, gd, ed, ge, ee);
    bus_cycle(1'b0, 1'b1, IO + 32'h0C, m_count, gd, ed, ge, ee);
    bus_cycle(1'b0, 1'b1, IO + 32'h10, 32'd1, gd, ed, ge, ee);
    bus_cycle(1'b0, 1'b1, IO, 32'hFF, gd, ed, ge, ee);
    bus_cycle(1'b0, 1'b1, RAM + 32'h14, 32'hCAFE_0001, gd, ed, ge, ee);
    n_checks++;
    if (gpio_out !== 8'hFF || timer_irq !== 1'b1) begin
      n_errors++; $display("FAIL pre_reset got=%h/%b exp=ff/1", gpio_out, timer_irq);
    end
    reset = 1'b1;
    bus_cycle(1'b0, 1'b1, RAM + 32'h14, 32'h0BAD_0BAD, gd, ed, ge, ee);
    reset = 1'b0;
    n_checks++;
    if (gpio_out !== 8'h00 || timer_irq !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset got=%h/%b exp=00/0", gpio_out, timer_irq);
    end
    bus_cycle(1'b1, 1'b0, IO + 32'h08, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (gd !== 32'h0) begin n_errors++; $display("FAIL mid_reset_count got=%h exp=0", gd); end
    bus_cycle(1'b1, 1'b0, RAM + 32'h14, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (gd !== 32'hCAFE_0001) begin n_errors++; $display("FAIL reset_write_dropped got=%h exp=cafe0001", gd); end
    bus_cycle(1'b1, 1'b0, 32'h1001_0500, 32'h0, gd, ed, ge, ee);
    n_checks++;
    if (ge !== 1'b1 || gd !== 32'h0) begin n_errors++; $display("FAIL unmapped_500 got=%h/%b exp=0/1", gd, ge); end
  endtask

  initial begin
    reset        = 1'b1;
    memread      = 1'b0;
    memwrite     = 1'b0;
    data_address = 32'h0;
    writedata    = 32'h0;
    gpio_in      = 8'h00;
    test_reset();
    test_ram();
    test_rw_same();
    test_errors();
    test_timer();
    test_gpio();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
